// File: rtl/main_memory_responder.sv
// main_memory_responder: fixed-latency 128-bit block store answering cache miss/writeback requests.
// Optional MAINMEM_RANGE_CHECK_EN adds err and rejects addresses beyond DEPTH blocks.
module main_memory_responder #(
  parameter int DEPTH = 1024,
  parameter int LATENCY = 20,
  parameter int INDEX_W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req,
  input  logic         we,
  input  logic [31:0]  addr,
  input  logic [127:0] wdata,
  output logic [127:0] rdata,
  output logic         ready,
`ifdef MAINMEM_RANGE_CHECK_EN
  output logic         err,
`endif
  output logic         busy
);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, next;
  logic [127:0] mem [DEPTH];
  logic [CW-1:0] cnt;
  logic [INDEX_W-1:0] idx;
  logic [127:0] wd;
  logic lat_we, oor, done, unused_bits;
  assign unused_bits = ^{addr[3:0], addr[31:INDEX_W+4]};
  assign done = state == WAIT && cnt == '0;
  assign ready = state == RESP;
  assign busy = state != IDLE;
`ifdef MAINMEM_RANGE_CHECK_EN
  assign err = ready && oor;
`endif
  always_comb begin
    next = state;
    if (state == IDLE) next = req ? WAIT : IDLE;
    else if (state == WAIT) next = done ? RESP : WAIT;
    else next = IDLE;
  end
  always_ff @(posedge clk) state <= reset ? IDLE : next;
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      rdata <= '0;
      idx <= '0;
      wd <= '0;
      lat_we <= 1'b0;
      oor <= 1'b0;
    end else if (state == IDLE && req) begin
      cnt <= CW'(LATENCY - 1);
      idx <= addr[INDEX_W+3:4];
      wd <= wdata;
      lat_we <= we;
`ifdef MAINMEM_RANGE_CHECK_EN
      oor <= |addr[31:INDEX_W+4];
`else
      oor <= 1'b0;
`endif
    end else if (state == WAIT) begin
      if (cnt != '0) cnt <= cnt - 1'b1;
      if (done && !lat_we) rdata <= oor ? '0 : mem[idx];
    end
  end
  // No reset here: contents survive reset, and a reset edge abandons the pending write.
  always_ff @(posedge clk)
    if (!reset && done && lat_we && !oor) mem[idx] <= wd;
endmodule

// File: tb/tb_main_memory_responder.sv
// tb_main_memory_responder: directed stimulus with a queue scoreboard checked by a ready monitor.
module tb_main_memory_responder;
  localparam int L = 20;
  logic clk = 0, reset = 1, req = 0, we = 0;
  logic [31:0] addr = 0;
  logic [127:0] wdata = 0, rdata;
  logic ready, busy, err_s;
`ifdef MAINMEM_RANGE_CHECK_EN
  logic err;
  assign err_s = err;
`else
  assign err_s = 1'b0;
`endif
  main_memory_responder #(.DEPTH(1024), .LATENCY(L), .INDEX_W(10)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ready(ready),
`ifdef MAINMEM_RANGE_CHECK_EN
    .err(err),
`endif
    .busy(busy));
  always #5 clk = ~clk;
  int cyc = 0, checks = 0, failures = 0, brun = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {logic [127:0] d; int c; logic e;} exp_t;
  exp_t sb[$];
  task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (reset) brun = 0;
    else begin
      brun = busy ? brun + 1 : 0;
      if (ready) begin
        if (sb.size() == 0) chk("unexpected_ready", 1, 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("ready_cycle", cyc, e.c);
          chk("rdata", rdata, e.d);
          chk("err", err_s, e.e);
          chk("busy_len", brun, L + 1);
        end
      end
    end
  end
  task automatic issue(input logic w, input logic [31:0] a, input logic [127:0] d,
                       input logic [127:0] er, input logic ee, input int acc);
    exp_t e;
    req = 1; we = w; addr = a; wdata = d;
    e.d = er; e.c = acc + L; e.e = ee;
    sb.push_back(e);
  endtask
  task automatic wait_ready(output int r);
    int n;
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (ready) break;
    end
    if (n == 100) chk("ready_timeout", 0, 1);
    r = cyc;
  endtask
  initial begin
    logic [127:0] d1, d2, w1, w2, a, b, c, prev;
    int r;
    d1 = 128'hdddddddd_cccccccc_bbbbbbbb_ffffffff;
    d2 = 128'h11111111_22222222_33333333_aaaaaaaa;
    w1 = 128'h01234567_89abcdef_fedcba98_76543210;
    w2 = 128'h5a5a5a5a_a5a5a5a5_0f0f0f0f_f0f0f0f0;
    a = 128'hcafef00d_00000001_00000002_00000003;
    b = 128'hbadbadba_dbadbadb_adbadbad_badbadba;
    c = 128'h20202020_21212121_22222222_23232323;
    repeat (3) @(negedge clk);
    reset = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_ready", ready, 0);
      chk("idle_busy", busy, 0);
      chk("idle_rdata", rdata, 0);
    end
    @(negedge clk) issue(1, 32'h0, d1, 0, 0, cyc + 1);
    wait_ready(r); req = 0;
    @(negedge clk) issue(0, 32'h8, 0, d1, 0, cyc + 1);
    wait_ready(r); req = 0;
`ifdef MAINMEM_RANGE_CHECK_EN
    @(negedge clk) issue(1, 32'h400c, d2, d1, 1, cyc + 1);
    wait_ready(r); req = 0;
    @(negedge clk) issue(0, 32'h0, 0, d1, 0, cyc + 1);
    prev = d1;
`else
    @(negedge clk) issue(1, 32'h400c, d2, d1, 0, cyc + 1);
    wait_ready(r); req = 0;
    @(negedge clk) issue(0, 32'h0, 0, d2, 0, cyc + 1);
    prev = d2;
`endif
    wait_ready(r); req = 0;
    @(negedge clk) issue(1, 32'h10, w1, prev, 0, cyc + 1);
    wait_ready(r); issue(0, 32'h10, 0, w1, 0, r + 2);
    wait_ready(r); issue(1, 32'h10, w2, w1, 0, r + 2);
    wait_ready(r); issue(0, 32'h10, 0, w2, 0, r + 2);
    wait_ready(r); req = 0;
    @(negedge clk) issue(1, 32'h30, a, w2, 0, cyc + 1);
    wait_ready(r); req = 0;
    @(negedge clk) begin req = 1; we = 1; addr = 32'h30; wdata = b; end
    repeat (10) @(negedge clk);
    reset = 1;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_ready", ready, 0);
    reset = 0; req = 0;
    repeat (3) @(negedge clk);
    chk("post_abort_idle", busy, 0);
    @(negedge clk) issue(0, 32'h30, 0, a, 0, cyc + 1);
    wait_ready(r); req = 0;
    @(negedge clk) issue(1, 32'h20, c, a, 0, cyc + 1);
    wait_ready(r); req = 0;
    @(negedge clk) issue(0, 32'h20, 0, c, 0, cyc + 1);
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (ready) break;
      addr = $urandom; wdata = {$urandom, $urandom, $urandom, $urandom}; we = ~we;
      if (n == 99) chk("toggle_timeout", 0, 1);
    end
    req = 0; we = 0;
    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
